// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch queue.
//             Queue entries pair a fetched word with the PC it came from.
//  Contents : FETCH_W           native data/PC width
//             RESET_PC_DEFAULT  first PC fetched after reset
//             PC_STEP           byte increment between sequential fetches
//             fetch_entry_t     {pc, instr} queue entry
//             align_word()      clear the byte-offset bits of an address
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

   localparam int FETCH_W = 32;

   localparam logic [FETCH_W-1:0] RESET_PC_DEFAULT = '0;
   localparam logic [FETCH_W-1:0] PC_STEP          = 32'd4;

   typedef struct packed {
      logic [FETCH_W-1:0] pc;
      logic [FETCH_W-1:0] instr;
   } fetch_entry_t;

   // Redirect targets may carry misaligned low bits; fetch is word-granular.
   function automatic logic [FETCH_W-1:0] align_word(input logic [FETCH_W-1:0] addr);
      return {addr[FETCH_W-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue_if
//  Purpose  : Bundles the instruction-memory read port and the decode-side
//             valid/ready handshake of the fetch queue.
//  Signals  : imem_req/imem_addr   fetch -> memory, read request + word addr
//             imem_rdata           memory -> fetch, data one cycle later
//             instr_valid/instr/instr_pc  fetch -> decode, queue head
//             instr_ready          decode -> fetch, head accepted
//  Modports : master = fetch unit side, slave = memory/decode side
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_queue_if #(
   parameter int WIDTH       = 32,
   parameter int IMEM_ADDR_W = 9
);
   logic                   imem_req;
   logic [IMEM_ADDR_W-1:0] imem_addr;
   logic [WIDTH-1:0]       imem_rdata;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [WIDTH-1:0]       instr;
   logic [WIDTH-1:0]       instr_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc,
      input  imem_rdata, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc,
      output imem_rdata, instr_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : DEPTH-entry circular buffer of fetch_entry_t with read/write
//             pointers, an occupancy count and a synchronous flush.
//  Ports    : clock, reset   clock / asynchronous active-high reset
//             flush          clear all entries at the next edge (wins)
//             push, wdata    enqueue an entry
//             pop            dequeue the head (ignored when empty)
//             rdata          head entry (raw storage, undefined when empty)
//             count, empty   occupancy
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  wire logic         clock,
   input  wire logic         reset,
   input  wire logic         flush,
   input  wire logic         push,
   input  wire fetch_entry_t wdata,
   input  wire logic         pop,
   output fetch_entry_t      rdata,
   output logic [CNT_W-1:0]  count,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count_q != '0);
   // A full queue may still accept a push when the head leaves in the same cycle.
   assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      if (do_push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_queue
//  Purpose  : Fetch stage ahead of decode. Issues word reads to a synchronous
//             instruction memory, queues returned words with their PCs and
//             hands them to decode over valid/ready. A redirect flushes the
//             queue, discards any response still in flight and refetches.
//  Ports    : clock, reset     clock / asynchronous active-high reset
//             redirect_valid   taken branch/jump from execute
//             redirect_pc      redirect target byte address
//             fetch_pc         PC of the next request (trace)
//             bus (master)     imem request/response + decode handshake
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int               WIDTH       = FETCH_W,
   parameter int               DEPTH       = 4,
   parameter int               IMEM_ADDR_W = 9,
   parameter logic [WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
   input  wire logic             clock,
   input  wire logic             reset,
   input  wire logic             redirect_valid,
   input  wire logic [WIDTH-1:0] redirect_pc,
   output logic      [WIDTH-1:0] fetch_pc,
   instr_fetch_queue_if.master   bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [WIDTH-1:0] req_pc_q,   req_pc_d;
   logic             inflight_q, inflight_d;

   logic             req;
   logic             push;
   logic             pop;
   logic             credit_ok;
   logic [CNT_W:0]   outstanding;
   logic [CNT_W-1:0] count;
   logic             empty;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   // Credit check: entries held plus the one response possibly on its way
   // must leave room, so every response is guaranteed a free slot.
   assign outstanding = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
   assign credit_ok   = outstanding < (CNT_W+1)'(DEPTH);
   assign req         = !reset && !redirect_valid && credit_ok;

   // A response landing during a redirect belongs to the abandoned path.
   assign push = inflight_q && !redirect_valid;
   assign pop  = bus.instr_valid && bus.instr_ready;

   assign push_entry = '{pc: req_pc_q, instr: bus.imem_rdata};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = align_word(redirect_pc);
      end else if (req) begin
         fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
      end
      inflight_d = req;
      req_pc_d   = req ? fetch_pc_q : req_pc_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .empty (empty)
   );

   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc_q[IMEM_ADDR_W+1:2];
   assign bus.instr_valid = !empty;
   // Head fields read as zero when nothing is queued.
   assign bus.instr       = empty ? '0 : head.instr;
   assign bus.instr_pc    = empty ? '0 : head.pc;
   assign fetch_pc        = fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_queue
//  Purpose  : Self-checking bench for instr_fetch_queue: a cycle table for
//             fill/drain/redirect, hand sequences for the multi-cycle corner
//             cases, and a randomized run against a stream-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_queue;
   import fetch_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 9;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic [31:0] fetch_pc;

   instr_fetch_queue_if #(.WIDTH(WIDTH), .IMEM_ADDR_W(AW)) bus ();

   instr_fetch_queue #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .IMEM_ADDR_W (AW),
      .RESET_PC    (32'h0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_pc       (fetch_pc),
      .bus            (bus)
   );

   always #5 clock = ~clock;

   // Instruction memory contents: a recognisable tag plus the word address.
   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return {16'hA5C3, 5'd0, pc[10:2], 2'b11};
   endfunction

   // Synchronous instruction memory: data one cycle after the request.
   always @(posedge clock) begin
      if (bus.imem_req) bus.imem_rdata <= word_of({21'd0, bus.imem_addr, 2'b00});
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs for one cycle (after the falling edge), then settle.
   task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clock);
      redirect_valid  = rv;
      redirect_pc     = rpc;
      bus.instr_ready = rdy;
      #1;
   endtask

   task automatic reset_dut();
      @(negedge clock);
      reset           = 1'b1;
      redirect_valid  = 1'b0;
      bus.instr_ready = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
   endtask

   task automatic chk_head(input string name, input logic [31:0] pc);
      chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
      chk({name, "_pc"},    bus.instr_pc, pc);
      chk({name, "_instr"}, bus.instr,    word_of(pc));
   endtask

   typedef struct {
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      logic        req;
      logic [8:0]  addr;
      logic [31:0] fpc;
      logic        valid;
      logic [31:0] ipc;
   } vec_t;

   function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                               input logic req, input logic [8:0] addr, input logic [31:0] fpc,
                               input logic valid, input logic [31:0] ipc);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.req = req;
      v.addr = addr; v.fpc = fpc; v.valid = valid; v.ipc = ipc;
      return v;
   endfunction

   vec_t tbl [16];

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] prev_pc;
      logic [31:0] prev_instr;
      logic        prev_hold;
      int          low_streak;
      logic        rv;
      logic        rdy;
      logic [31:0] rpc;
      logic [31:0] exp_instr;

      bus.instr_ready = 1'b0;

      // Fill with decode stalled, drain, then a misaligned redirect.
      tbl[0]  = mk(0, 0,      0, 1, 9'h000, 32'h000, 0, 32'h000);
      tbl[1]  = mk(0, 0,      0, 1, 9'h001, 32'h004, 0, 32'h000);
      tbl[2]  = mk(0, 0,      0, 1, 9'h002, 32'h008, 1, 32'h000);
      tbl[3]  = mk(0, 0,      0, 1, 9'h003, 32'h00C, 1, 32'h000);
      tbl[4]  = mk(0, 0,      0, 0, 9'h004, 32'h010, 1, 32'h000);
      tbl[5]  = mk(0, 0,      0, 0, 9'h004, 32'h010, 1, 32'h000);
      tbl[6]  = mk(0, 0,      0, 0, 9'h004, 32'h010, 1, 32'h000);
      tbl[7]  = mk(0, 0,      1, 0, 9'h004, 32'h010, 1, 32'h000);
      tbl[8]  = mk(0, 0,      1, 1, 9'h004, 32'h010, 1, 32'h004);
      tbl[9]  = mk(0, 0,      1, 1, 9'h005, 32'h014, 1, 32'h008);
      tbl[10] = mk(0, 0,      1, 1, 9'h006, 32'h018, 1, 32'h00C);
      tbl[11] = mk(0, 0,      1, 1, 9'h007, 32'h01C, 1, 32'h010);
      tbl[12] = mk(1, 32'h103, 0, 0, 9'h008, 32'h020, 1, 32'h014);
      tbl[13] = mk(0, 0,      1, 1, 9'h040, 32'h100, 0, 32'h000);
      tbl[14] = mk(0, 0,      1, 1, 9'h041, 32'h104, 0, 32'h000);
      tbl[15] = mk(0, 0,      1, 1, 9'h042, 32'h108, 1, 32'h100);

      // ---- reset state (while reset is held) ----
      @(negedge clock);
      #1;
      chk("rst_valid",    32'(bus.instr_valid), 32'd0);
      chk("rst_instr",    bus.instr,            32'd0);
      chk("rst_instr_pc", bus.instr_pc,         32'd0);
      chk("rst_req",      32'(bus.imem_req),    32'd0);
      chk("rst_fetch_pc", fetch_pc,             32'd0);

      // ---- table: fill, stall, drain, misaligned redirect ----
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
         exp_instr = tbl[i].valid ? word_of(tbl[i].ipc) : 32'd0;
         chk($sformatf("t%0d_req", i),   32'(bus.imem_req),    32'(tbl[i].req));
         chk($sformatf("t%0d_addr", i),  32'(bus.imem_addr),   32'(tbl[i].addr));
         chk($sformatf("t%0d_fpc", i),   fetch_pc,             tbl[i].fpc);
         chk($sformatf("t%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
         chk($sformatf("t%0d_ipc", i),   bus.instr_pc,         tbl[i].ipc);
         chk($sformatf("t%0d_instr", i), bus.instr,            exp_instr);
      end

      // ---- redirect while a response is in flight ----
      reset_dut();
      drive(0, 0, 1);
      chk("inflt_req0", 32'(bus.imem_req), 32'd1);
      drive(1, 32'h100, 1);
      chk("inflt_noreq", 32'(bus.imem_req), 32'd0);
      drive(0, 0, 1);
      chk("inflt_v2",   32'(bus.instr_valid), 32'd0);
      chk("inflt_addr", 32'(bus.imem_addr),   32'h40);
      drive(0, 0, 1);
      chk("inflt_v3", 32'(bus.instr_valid), 32'd0);
      drive(0, 0, 1);
      chk_head("inflt_tgt", 32'h100);
      drive(0, 0, 1);
      chk_head("inflt_tgt4", 32'h104);

      // ---- handshake in the redirect cycle ----
      reset_dut();
      drive(0, 0, 1);
      drive(0, 0, 1);
      drive(0, 0, 1);
      chk_head("hs_h0", 32'h0);
      drive(1, 32'h200, 1);
      chk_head("hs_h1", 32'h4);
      drive(0, 0, 1);
      chk("hs_gap1", 32'(bus.instr_valid), 32'd0);
      drive(0, 0, 1);
      chk("hs_gap2", 32'(bus.instr_valid), 32'd0);
      drive(0, 0, 1);
      chk_head("hs_tgt", 32'h200);
      drive(0, 0, 1);
      chk_head("hs_tgt4", 32'h204);

      // ---- asynchronous reset with a full queue ----
      reset_dut();
      repeat (8) drive(0, 0, 0);
      chk_head("ar_full", 32'h0);
      chk("ar_full_req", 32'(bus.imem_req), 32'd0);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", 32'(bus.instr_valid), 32'd0);
      chk("ar_req",   32'(bus.imem_req),    32'd0);
      chk("ar_fpc",   fetch_pc,             32'd0);
      chk("ar_ipc",   bus.instr_pc,         32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      drive(0, 0, 1);
      chk("ar_rs_req",  32'(bus.imem_req),  32'd1);
      chk("ar_rs_addr", 32'(bus.imem_addr), 32'd0);
      drive(0, 0, 1);
      drive(0, 0, 1);
      chk_head("ar_rs_h0", 32'h0);

      // ---- imem address wrap ----
      reset_dut();
      drive(1, 32'h7F4, 1);
      drive(0, 0, 1);
      chk("wr_a1", 32'(bus.imem_addr), 32'h1FD);
      drive(0, 0, 1);
      chk("wr_a2", 32'(bus.imem_addr), 32'h1FE);
      drive(0, 0, 1);
      chk("wr_a3", 32'(bus.imem_addr), 32'h1FF);
      chk("wr_f3", fetch_pc,           32'h7FC);
      chk_head("wr_h3", 32'h7F4);
      drive(0, 0, 1);
      chk("wr_a4", 32'(bus.imem_addr), 32'h000);
      chk("wr_f4", fetch_pc,           32'h800);
      chk_head("wr_h4", 32'h7F8);
      drive(0, 0, 1);
      chk_head("wr_h5", 32'h7FC);
      drive(0, 0, 1);
      chk_head("wr_h6", 32'h800);

      // ---- randomized run against the expected instruction stream ----
      reset_dut();
      exp_pc     = 32'h0;
      prev_hold  = 1'b0;
      prev_pc    = '0;
      prev_instr = '0;
      low_streak = 0;
      for (int i = 0; i < 3000; i++) begin
         rv  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) rpc = 32'h7F0 + 32'($urandom_range(0, 15));
         else                           rpc = 32'($urandom_range(0, 4095));
         drive(rv, rpc, rdy);

         if (prev_hold) begin
            chk("rnd_hold_valid", 32'(bus.instr_valid), 32'd1);
            chk("rnd_hold_pc",    bus.instr_pc,         prev_pc);
            chk("rnd_hold_instr", bus.instr,            prev_instr);
         end
         if (rv) chk("rnd_redir_noreq", 32'(bus.imem_req), 32'd0);
         chk("rnd_addr", 32'(bus.imem_addr), {23'd0, fetch_pc[10:2]});

         // The head must always be the next instruction of the current path.
         if (bus.instr_valid) begin
            chk("rnd_head_pc",    bus.instr_pc, exp_pc);
            chk("rnd_head_instr", bus.instr,    word_of(exp_pc));
            if (rdy) exp_pc = exp_pc + 32'd4;
         end
         if (rv) exp_pc = {rpc[31:2], 2'b00};

         if (rv || bus.instr_valid) low_streak = 0;
         else                       low_streak++;
         if (low_streak > 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rnd_starve: got %0d idle cycles expected at most 4", low_streak);
            low_streak = 0;
         end

         prev_hold  = bus.instr_valid && !rdy && !rv;
         prev_pc    = bus.instr_pc;
         prev_instr = bus.instr;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
